// File: rtl/ifetch_responder_pkg.sv
// rtl/ifetch_responder_pkg.sv - shared state encoding and defaults for the fetch responder
package ifetch_responder_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam logic [15:0] RESET_ADDR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        DRAIN = 2'b10
    } state_t;

endpackage

// File: rtl/ifetch_responder_resp_fifo.sv
// rtl/ifetch_responder_resp_fifo.sv - response FIFO with synchronous flush and occupancy count
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot the same edge, so push at full is legal when popping.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/ifetch_responder.sv
// rtl/ifetch_responder.sv - fixed-latency instruction fetch responder with buffered responses
module ifetch_responder
    import ifetch_responder_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int LAT   = 2,
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RE,
    input  logic          FLUSH,
    input  logic          REQ_VALID,
    input  logic [AW-1:0] REQ_ADDR,
    output logic          REQ_READY,
    output logic          MEM_RD,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [DW-1:0] MEM_DATA,
    output logic          RSP_VALID,
    output logic [AW-1:0] RSP_ADDR,
    output logic [DW-1:0] RSP_DATA,
    input  logic          RSP_READY
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t          state;
    state_t          state_next;
    logic [2:0]      cnt;
    logic [CW-1:0]   fifo_count;
    logic            accept;
    logic            capture;
    logic [AW+DW-1:0] head;

    assign REQ_READY = (state == IDLE) && !FLUSH && !RE && (fifo_count < FULL);
    assign accept    = REQ_VALID && REQ_READY;
    // Counter reaches zero in the cycle the memory word is valid.
    assign capture   = (state == WAIT) && (cnt == 3'd0) && !FLUSH;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_next = IDLE;
                end else if (FLUSH) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == 3'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RE) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            MEM_RD   <= 1'b0;
            MEM_ADDR <= AW'(RESET_ADDR);
        end else begin
            state  <= state_next;
            MEM_RD <= accept;
            if (accept) begin
                MEM_ADDR <= REQ_ADDR;
                cnt      <= 3'(LAT);
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    resp_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RE),
        .flush (FLUSH),
        .push  (capture),
        .din   ({MEM_ADDR, MEM_DATA}),
        .pop   (RSP_READY),
        .dout  (head),
        .valid (RSP_VALID),
        .count (fifo_count)
    );

    assign RSP_ADDR = head[AW+DW-1:DW];
    assign RSP_DATA = head[DW-1:0];

endmodule
